tlc_phase_sched: RTL and testbench
==================================

Name: tlc_phase_sched

Overview:
Phase scheduler for the highway/farm-road traffic-light intersection. It owns the 31-bit phase timer and sequences the six light phases. It latches farm-road vehicle-sensor requests so highway green is extended until a farm vehicle is waiting. It drives the per-road light codes and exposes state, Count and RstCount for debug and for downstream light drivers.

Parameters:
ALLRED_CYC, 50000000, all-red phase length in clock cycles (1 s at 50 MHz)
HWY_GREEN_MIN, 1500000000, highway green length, or minimum length when sensor mode is on (30 s)
YELLOW_CYC, 150000000, yellow length for either road (3 s)
FARM_GREEN_CYC, 750000000, farm-road green length (15 s)

Ports:
Clk  input  1  system clock, all logic on rising edge
Rst_n  input  1  asynchronous active-low reset
FarmSensor  input  1  farm-road vehicle detector, level, synchronous to Clk
state  output  3  current phase, for debug
highwaySignal  output  2  highway light: GREEN=00, YELLOW=01, RED=10
farmSignal  output  2  farm light, same encoding
Count  output  31  phase timer, cycles elapsed in current phase
RstCount  output  1  high during the last cycle of a phase (terminal count)
FarmPending  output  1  latched farm-road request

Behaviour:
- Reset: Rst_n low asynchronously forces the following, with no clock edge required:
  - state=S0, Count=0, FarmPending=0, RstCount=0
  - highwaySignal=RED, farmSignal=RED
  - Reset mid-phase abandons the phase; there is no resume.
- Phases: duration D, highway light / farm light, next phase:
  - S0 (000) ALLRED_CYC, RED/RED, ->S1
  - S1 (001) HWY_GREEN_MIN, GREEN/RED, ->S2
  - S2 (010) YELLOW_CYC, YELLOW/RED, ->S3
  - S3 (011) ALLRED_CYC, RED/RED, ->S4
  - S4 (100) FARM_GREEN_CYC, RED/GREEN, ->S5
  - S5 (101) YELLOW_CYC, RED/YELLOW, ->S0
  - Codes 110 and 111 are illegal: they go to S0 on the next edge and drive RED/RED.
- Light outputs are Moore only: decoded from the state register alone, with no input-to-output paths.
- Timer:
  - tc = (Count == D-1) for the current phase; in S1 it is further qualified (see Optional Feature).
  - RstCount = tc, combinational from registers only.
  - On a clock edge with tc=1: state <= next phase, Count <= 0. Otherwise Count <= Count+1.
  - Each phase therefore lasts exactly D cycles; D=1 gives a single-cycle phase.
  - D must be between 1 and 2^31-1. Count never wraps.
- FarmPending:
  - Set on an edge where FarmSensor=1 and state is not S4.
  - Cleared on the edge that enters S4; the clear takes priority over the set.
  - Held otherwise.
  - Sensor activity during S4 is ignored (the vehicle is being served).
- Full fixed-time cycle = 2*ALLRED_CYC + HWY_GREEN_MIN + 2*YELLOW_CYC + FARM_GREEN_CYC cycles.

Optional Feature:
Macro TLC_SENSOR_EN.
- Defined: in S1, Count saturates at HWY_GREEN_MIN-1. tc in S1 = (Count == HWY_GREEN_MIN-1) && FarmPending, so highway green holds indefinitely until a request is latched. A request latched at edge t gives RstCount=1 in the cycle after t and state=S2 one edge later. A request latched before the minimum expires causes exit exactly at minimum length.
- Undefined: FarmSensor does not affect sequencing; S1 always lasts HWY_GREEN_MIN cycles. FarmPending is still maintained for observation.

Test Plan:
Bench parameters: ALLRED=4, HWY_GREEN_MIN=10, YELLOW=3, FARM_GREEN=6.
1. TLC_SENSOR_EN undefined, FarmSensor=0, release reset -> state dwells 4/10/3/4/6/3 cycles in S0..S5, then S0 again (30-cycle period). RstCount high on cycles 3, 13, 16, 20, 26, 29 after release. Lights match the phase list.
2. TLC_SENSOR_EN defined, FarmSensor=0 -> S1 holds with Count stuck at 9 and RstCount=0 for 100 cycles. A 1-cycle FarmSensor pulse sampled at edge t -> FarmPending=1 after t, RstCount=1 in the following cycle, state=S2 one edge later.
3. TLC_SENSOR_EN defined, FarmSensor high at S1 Count=2 for 1 cycle -> FarmPending=1 and S1 exits at exactly 10 cycles. FarmPending clears on the edge entering S4.
4. TLC_SENSOR_EN defined, FarmSensor high only while in S4 -> FarmPending stays 0 and the next S1 holds at Count=9. Pulse during S5 instead -> FarmPending=1 and the next S1 lasts 10 cycles.
5. Assert Rst_n=0 asynchronously (between edges) in S4 at Count=3 -> immediately state=0, Count=0, RED/RED, FarmPending=0. After release, the S0 dwell is 4 cycles.
6. Force state to 3'b110 via a bench hook -> outputs RED/RED and state=S0 on the next edge with Count=0.

Source files
------------

// File: rtl/tlc_phase_sched.sv
// ============================================================================
// Module   : tlc_phase_sched
// Purpose  : Phase timer and six-phase light sequencer for a highway/farm-road
//            intersection. Define TLC_SENSOR_EN to hold highway green until a
//            farm-road request has been latched.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tlc_phase_sched #(
  parameter int unsigned ALLRED_CYC     = 50000000,
  parameter int unsigned HWY_GREEN_MIN  = 1500000000,
  parameter int unsigned YELLOW_CYC     = 150000000,
  parameter int unsigned FARM_GREEN_CYC = 750000000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        FarmSensor,
  output logic [2:0]  state,
  output logic [1:0]  highwaySignal,
  output logic [1:0]  farmSignal,
  output logic [30:0] Count,
  output logic        RstCount,
  output logic        FarmPending
);

  localparam logic [2:0] c_s0 = 3'd0;
  localparam logic [2:0] c_s1 = 3'd1;
  localparam logic [2:0] c_s2 = 3'd2;
  localparam logic [2:0] c_s3 = 3'd3;
  localparam logic [2:0] c_s4 = 3'd4;
  localparam logic [2:0] c_s5 = 3'd5;

  localparam logic [1:0] c_green  = 2'b00;
  localparam logic [1:0] c_yellow = 2'b01;
  localparam logic [1:0] c_red    = 2'b10;

  localparam logic [30:0] c_allred_last = 31'(ALLRED_CYC - 1);
  localparam logic [30:0] c_hwy_last    = 31'(HWY_GREEN_MIN - 1);
  localparam logic [30:0] c_yellow_last = 31'(YELLOW_CYC - 1);
  localparam logic [30:0] c_farm_last   = 31'(FARM_GREEN_CYC - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [30:0] r_count;
  logic [30:0] w_count_nxt;
  logic [30:0] w_last;
  logic        r_farm_pend;
  logic        w_farm_pend_nxt;
  logic        w_illegal;
  logic        w_at_last;
  logic        w_hold;
  logic        w_tc;

  always_ff @(posedge Clk or negedge Rst_n) begin : p_regs
    if (!Rst_n) begin
      r_state     <= c_s0;
      r_count     <= '0;
      r_farm_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_farm_pend <= w_farm_pend_nxt;
    end
  end

  always_comb begin : p_next
    w_last      = '0;
    w_illegal   = 1'b0;
    w_state_nxt = c_s0;
    case (r_state)
      c_s0:    begin w_last = c_allred_last; w_state_nxt = c_s1; end
      c_s1:    begin w_last = c_hwy_last;    w_state_nxt = c_s2; end
      c_s2:    begin w_last = c_yellow_last; w_state_nxt = c_s3; end
      c_s3:    begin w_last = c_allred_last; w_state_nxt = c_s4; end
      c_s4:    begin w_last = c_farm_last;   w_state_nxt = c_s5; end
      c_s5:    begin w_last = c_yellow_last; w_state_nxt = c_s0; end
      default: w_illegal = 1'b1;
    endcase

    w_at_last = (r_count == w_last);
`ifdef TLC_SENSOR_EN
    // Highway green parks at its minimum until a farm request is latched.
    w_tc   = w_at_last && ((r_state != c_s1) || r_farm_pend);
    w_hold = w_at_last && (r_state == c_s1) && !r_farm_pend;
`else
    w_tc   = w_at_last;
    w_hold = 1'b0;
`endif
    if (w_illegal) begin
      w_tc = 1'b1;
    end

    if (w_tc) begin
      w_count_nxt = '0;
    end else if (w_hold) begin
      w_count_nxt = r_count;
      w_state_nxt = r_state;
    end else begin
      w_count_nxt = r_count + 31'd1;
      w_state_nxt = r_state;
    end

    // Entering farm green serves the request; that clear beats a new set.
    w_farm_pend_nxt = r_farm_pend | (FarmSensor && (r_state != c_s4));
    if (w_tc && (w_state_nxt == c_s4)) begin
      w_farm_pend_nxt = 1'b0;
    end
  end

  always_comb begin : p_out
    highwaySignal = c_red;
    farmSignal    = c_red;
    case (r_state)
      c_s1:    highwaySignal = c_green;
      c_s2:    highwaySignal = c_yellow;
      c_s4:    farmSignal    = c_green;
      c_s5:    farmSignal    = c_yellow;
      default: ;
    endcase
    state       = r_state;
    Count       = r_count;
    RstCount    = w_tc;
    FarmPending = r_farm_pend;
  end

endmodule

`default_nettype wire

// File: tb/tb_tlc_phase_sched.sv
// ============================================================================
// Module   : tb_tlc_phase_sched
// Purpose  : Self-checking bench for tlc_phase_sched; expected per-cycle
//            outputs are queued from the phase table and popped each cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tlc_phase_sched;

`ifdef TLC_SENSOR_EN
  localparam bit SENSOR = 1'b1;
`else
  localparam bit SENSOR = 1'b0;
`endif

  logic        Clk;
  logic        Rst_n;
  logic        FarmSensor;
  logic [2:0]  state;
  logic [1:0]  highwaySignal;
  logic [1:0]  farmSignal;
  logic [30:0] Count;
  logic        RstCount;
  logic        FarmPending;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        sens;
    logic [2:0]  st;
    logic [30:0] cnt;
    logic        rc;
    logic        fp;
  } exp_t;

  exp_t q[$];

  tlc_phase_sched #(
    .ALLRED_CYC    (4),
    .HWY_GREEN_MIN (10),
    .YELLOW_CYC    (3),
    .FARM_GREEN_CYC(6)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .FarmSensor   (FarmSensor),
    .state        (state),
    .highwaySignal(highwaySignal),
    .farmSignal   (farmSignal),
    .Count        (Count),
    .RstCount     (RstCount),
    .FarmPending  (FarmPending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int dur(input logic [2:0] st);
    case (st)
      3'd0, 3'd3: return 4;
      3'd1:       return 10;
      3'd2, 3'd5: return 3;
      3'd4:       return 6;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [1:0] exp_hwy(input logic [2:0] st);
    case (st)
      3'd1:    return 2'b00;
      3'd2:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] exp_farm(input logic [2:0] st);
    case (st)
      3'd4:    return 2'b00;
      3'd5:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic string show(input logic [2:0] st, input logic [30:0] cnt,
                                 input logic rc, input logic fp,
                                 input logic [1:0] h, input logic [1:0] f);
    return $sformatf("st=%0d cnt=%0d rc=%0b fp=%0b hwy=%b farm=%b", st, cnt, rc, fp, h, f);
  endfunction

  // Queue n cycles (n<0: whole phase) of a phase; sensor driven at pulse_at.
  task automatic push_phase(input logic [2:0] st, input int pulse_at,
                            input bit sens_all, input int n, inout logic fp);
    exp_t e;
    int   d;
    int   lim;
    d   = dur(st);
    lim = (n < 0) ? d : n;
    if (st == 3'd4) fp = 1'b0;
    for (int i = 0; i < lim; i++) begin
      e.st   = st;
      e.cnt  = 31'(i);
      e.fp   = fp;
      e.rc   = (i == d - 1) && (!SENSOR || (st != 3'd1) || fp);
      e.sens = sens_all || (i == pulse_at);
      q.push_back(e);
      if (e.sens && (st != 3'd4)) fp = 1'b1;
    end
  endtask

  // Parked highway green: Count held at 9 until the latched request exits.
  task automatic push_hold(input int pulse_at, inout logic fp);
    exp_t e;
    for (int i = 0; i < 400; i++) begin
      e.st   = 3'd1;
      e.cnt  = 31'd9;
      e.fp   = fp;
      e.rc   = fp;
      e.sens = (i == pulse_at);
      q.push_back(e);
      if (e.rc) break;
      if (e.sens) fp = 1'b1;
    end
  endtask

  task automatic apply_reset();
    #2 Rst_n = 1'b0;
    FarmSensor = 1'b0;
    q.delete();
    repeat (2) @(posedge Clk);
    #3 Rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    Rst_n      = 1'b0;
    FarmSensor = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({state, Count, RstCount, FarmPending, highwaySignal, farmSignal} !==
        {3'd0, 31'd0, 1'b0, 1'b0, 2'b10, 2'b10}) begin
      failures++;
      $display("FAIL reset got %s want %s",
               show(state, Count, RstCount, FarmPending, highwaySignal, farmSignal),
               show(3'd0, 31'd0, 1'b0, 1'b0, 2'b10, 2'b10));
    end
    FarmSensor = 1'b0;
  endtask

`ifndef TLC_SENSOR_EN
  task automatic test_fixed_cycle();
    exp_t e;
    logic fp;
    int   cyc;
    apply_reset();
    fp = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 6; p++) push_phase(3'(p), -1, 1'b0, -1, fp);
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({state, Count, RstCount, FarmPending, highwaySignal, farmSignal} !==
          {e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)}) begin
        failures++;
        $display("FAIL fixed_cycle cyc=%0d got %s want %s", cyc,
                 show(state, Count, RstCount, FarmPending, highwaySignal, farmSignal),
                 show(e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)));
      end
      FarmSensor = e.sens;
      @(posedge Clk); #1;
      cyc++;
    end
    FarmSensor = 1'b0;
  endtask
`else
  task automatic test_sensor_hold();
    exp_t e;
    logic fp;
    int   cyc;
    apply_reset();
    fp = 1'b0;
    push_phase(3'd0, -1, 1'b0, -1, fp);
    push_phase(3'd1, -1, 1'b0, -1, fp);
    push_hold(99, fp);
    push_phase(3'd2, -1, 1'b0, -1, fp);
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({state, Count, RstCount, FarmPending, highwaySignal, farmSignal} !==
          {e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)}) begin
        failures++;
        $display("FAIL sensor_hold cyc=%0d got %s want %s", cyc,
                 show(state, Count, RstCount, FarmPending, highwaySignal, farmSignal),
                 show(e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)));
      end
      FarmSensor = e.sens;
      @(posedge Clk); #1;
      cyc++;
    end
    FarmSensor = 1'b0;
  endtask
`endif

  task automatic test_early_request();
    exp_t e;
    logic fp;
    int   cyc;
    apply_reset();
    fp = 1'b0;
    push_phase(3'd0, -1, 1'b0, -1, fp);
    push_phase(3'd1, 2, 1'b0, -1, fp);
    for (int p = 2; p < 6; p++) push_phase(3'(p), -1, 1'b0, -1, fp);
    push_phase(3'd0, -1, 1'b0, 2, fp);
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({state, Count, RstCount, FarmPending, highwaySignal, farmSignal} !==
          {e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)}) begin
        failures++;
        $display("FAIL early_request cyc=%0d got %s want %s", cyc,
                 show(state, Count, RstCount, FarmPending, highwaySignal, farmSignal),
                 show(e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)));
      end
      FarmSensor = e.sens;
      @(posedge Clk); #1;
      cyc++;
    end
    FarmSensor = 1'b0;
  endtask

  task automatic test_s4_requests();
    exp_t e;
    logic fp;
    int   cyc;
    apply_reset();
    fp = 1'b0;
    push_phase(3'd0, 0, 1'b0, -1, fp);
    for (int p = 1; p < 4; p++) push_phase(3'(p), -1, 1'b0, -1, fp);
    push_phase(3'd4, -1, 1'b1, -1, fp);
    push_phase(3'd5, -1, 1'b0, -1, fp);
    push_phase(3'd0, -1, 1'b0, -1, fp);
    push_phase(3'd1, -1, 1'b0, -1, fp);
    if (SENSOR) push_hold(9, fp);
    for (int p = 2; p < 5; p++) push_phase(3'(p), -1, 1'b0, -1, fp);
    push_phase(3'd5, 0, 1'b0, -1, fp);
    push_phase(3'd0, -1, 1'b0, -1, fp);
    push_phase(3'd1, -1, 1'b0, -1, fp);
    push_phase(3'd2, -1, 1'b0, 1, fp);
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({state, Count, RstCount, FarmPending, highwaySignal, farmSignal} !==
          {e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)}) begin
        failures++;
        $display("FAIL s4_requests cyc=%0d got %s want %s", cyc,
                 show(state, Count, RstCount, FarmPending, highwaySignal, farmSignal),
                 show(e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)));
      end
      FarmSensor = e.sens;
      @(posedge Clk); #1;
      cyc++;
    end
    FarmSensor = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic fp;
    int   cyc;
    apply_reset();
    fp = 1'b0;
    push_phase(3'd0, 0, 1'b0, -1, fp);
    for (int p = 1; p < 4; p++) push_phase(3'(p), -1, 1'b0, -1, fp);
    push_phase(3'd4, -1, 1'b0, 3, fp);
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({state, Count, RstCount, FarmPending, highwaySignal, farmSignal} !==
          {e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)}) begin
        failures++;
        $display("FAIL async_pre cyc=%0d got %s want %s", cyc,
                 show(state, Count, RstCount, FarmPending, highwaySignal, farmSignal),
                 show(e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)));
      end
      FarmSensor = e.sens;
      @(posedge Clk); #1;
      cyc++;
    end
    FarmSensor = 1'b0;
    // Now in S4 at Count=3; drop reset between edges.
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if ({state, Count, RstCount, FarmPending, highwaySignal, farmSignal} !==
        {3'd0, 31'd0, 1'b0, 1'b0, 2'b10, 2'b10}) begin
      failures++;
      $display("FAIL async_assert got %s want %s",
               show(state, Count, RstCount, FarmPending, highwaySignal, farmSignal),
               show(3'd0, 31'd0, 1'b0, 1'b0, 2'b10, 2'b10));
    end
    #2 Rst_n = 1'b1;
    #1;
    fp = 1'b0;
    push_phase(3'd0, -1, 1'b0, -1, fp);
    push_phase(3'd1, -1, 1'b0, 1, fp);
    cyc = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({state, Count, RstCount, FarmPending, highwaySignal, farmSignal} !==
          {e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)}) begin
        failures++;
        $display("FAIL async_dwell cyc=%0d got %s want %s", cyc,
                 show(state, Count, RstCount, FarmPending, highwaySignal, farmSignal),
                 show(e.st, e.cnt, e.rc, e.fp, exp_hwy(e.st), exp_farm(e.st)));
      end
      @(posedge Clk); #1;
      cyc++;
    end
  endtask

  task automatic test_illegal_state();
    logic fp;
    apply_reset();
    fp = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    force dut.r_state = 3'b110;
    #1;
    checks++;
    if ({state, highwaySignal, farmSignal} !== {3'b110, 2'b10, 2'b10}) begin
      failures++;
      $display("FAIL illegal_lights got st=%0d hwy=%b farm=%b want st=6 hwy=10 farm=10",
               state, highwaySignal, farmSignal);
    end
    #2 release dut.r_state;
    @(posedge Clk); #1;
    checks++;
    if ({state, Count, highwaySignal, farmSignal, FarmPending} !==
        {3'd0, 31'd0, 2'b10, 2'b10, fp}) begin
      failures++;
      $display("FAIL illegal_recover got st=%0d cnt=%0d hwy=%b farm=%b want st=0 cnt=0 hwy=10 farm=10",
               state, Count, highwaySignal, farmSignal);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n      = 1'b0;
    FarmSensor = 1'b0;
    test_reset();
`ifndef TLC_SENSOR_EN
    test_fixed_cycle();
`else
    test_sensor_hold();
`endif
    test_early_request();
    test_s4_requests();
    test_async_reset();
    test_illegal_state();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
